// File: rtl/datatypes.sv
// Shared types for the immediate generator pipeline.
// Holds the instruction-format encoding and the skid-buffer occupancy state.
// No ports; imported by imm_extract and imm_gen_pipe.
package datatypes;

  // Instruction format selector driven by the decoder alongside the IR word.
  // Codes 5..7 are unused and decode as illegal.
  typedef enum logic [2:0] {
    INSTR_I = 3'd0,
    INSTR_S = 3'd1,
    INSTR_B = 3'd2,
    INSTR_U = 3'd3,
    INSTR_J = 3'd4
  } instr_type_t;

  // Occupancy of the output register + skid register pair.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } imm_buf_state_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction for RV32/RV64 base formats (and RVC when
// IMM_GEN_RVC_EN is defined). Latency 0; no handshake.
// Ports: ir_i (instruction word), type_i (format), rvc_i (compressed flag),
//        res_o = {illegal, imm[XLEN-1:0]}; illegal forces imm to zero.
module imm_extract
  import datatypes::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]   ir_i,
  input  instr_type_t   type_i,
  input  logic          rvc_i,
  output logic [XLEN:0] res_o
);

  // Every supported immediate fits in 32 bits signed; widen once at the end.
  logic [31:0] imm32;
  logic        illegal;

  // Opcode/quadrant bits never feed an immediate.
  logic unused_ir;
  assign unused_ir = ^ir_i[6:0];

  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    if (!rvc_i) begin
      case (type_i)
        INSTR_I: imm32 = {{20{ir_i[31]}}, ir_i[31:20]};
        INSTR_S: imm32 = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
        INSTR_B: imm32 = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25],
                          ir_i[11:8], 1'b0};
        // Upper-immediate is already 32 bits; sign extension to 64 happens below.
        INSTR_U: imm32 = {ir_i[31:12], 12'b0};
        INSTR_J: imm32 = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20],
                          ir_i[30:21], 1'b0};
        default: illegal = 1'b1;
      endcase
    end else begin
`ifdef IMM_GEN_RVC_EN
      case (type_i)
        // CI: imm[5|4:0] = ir[12|6:2]
        INSTR_I: imm32 = {{26{ir_i[12]}}, ir_i[12], ir_i[6:2]};
        // CB: imm[8|4:3] = ir[12:10], imm[7:6|2:1|5] = ir[6:2]
        INSTR_B: imm32 = {{23{ir_i[12]}}, ir_i[12], ir_i[6:5], ir_i[2],
                          ir_i[11:10], ir_i[4:3], 1'b0};
        // CJ: imm[11|4|9:8|10|6|7|3:1|5] = ir[12:2]
        INSTR_J: imm32 = {{20{ir_i[12]}}, ir_i[12], ir_i[8], ir_i[10:9],
                          ir_i[6], ir_i[7], ir_i[2], ir_i[11], ir_i[5:3], 1'b0};
        default: illegal = 1'b1;
      endcase
`else
      illegal = 1'b1;
`endif
    end
  end

  generate
    if (XLEN > 32) begin : g_wide
      assign res_o = {illegal, {(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
      assign res_o = {illegal, imm32};
    end
  endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one immediate per accepted word, 1-cycle
// latency, in order, through an output register plus one skid register.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_ir/in_type/in_rvc
// upstream; out_valid/out_ready/out_imm/out_illegal downstream.
// in_ready is registered and drops once both entries hold unconsumed results.
// Optional RVC extraction: define IMM_GEN_RVC_EN.
module imm_gen_pipe
  import datatypes::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [2:0]      in_type,
  input  logic            in_rvc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  imm_buf_state_t cnt_q, cnt_d;
  logic           in_ready_q;
  logic [XLEN:0]  out_res_q, skid_res_q;   // {illegal, imm}
  logic [XLEN:0]  new_res;

  logic in_xfer, out_xfer;
  logic load_out, load_skid, out_from_skid;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .ir_i   (in_ir),
    .type_i (instr_type_t'(in_type)),
    .rvc_i  (in_rvc),
    .res_o  (new_res)
  );

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid & out_ready;

  // State register (also the registered in_ready).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= BUF_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      in_ready_q <= (cnt_d != BUF_FULL);
    end
  end

  // Next-state logic.
  always_comb begin
    cnt_d = cnt_q;
    case (cnt_q)
      BUF_EMPTY: if (in_xfer) cnt_d = BUF_ONE;
      BUF_ONE: begin
        if (in_xfer && !out_xfer)      cnt_d = BUF_FULL;
        else if (!in_xfer && out_xfer) cnt_d = BUF_EMPTY;
      end
      BUF_FULL:  if (out_xfer) cnt_d = BUF_ONE;
      default:   cnt_d = BUF_EMPTY;
    endcase
  end

  // Output / datapath-control decode.
  always_comb begin
    out_valid     = (cnt_q != BUF_EMPTY);
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (cnt_q)
      BUF_EMPTY: load_out = in_xfer;
      BUF_ONE: begin
        // Head leaving while a new one arrives: new result goes straight to
        // the output register; otherwise it parks in the skid register.
        load_out  = in_xfer & out_xfer;
        load_skid = in_xfer & ~out_xfer;
      end
      BUF_FULL: begin
        load_out      = out_xfer;
        out_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  // Result storage; holds steady while stalled because loads only happen on
  // transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_res_q  <= '0;
      skid_res_q <= '0;
    end else begin
      if (load_out)  out_res_q  <= out_from_skid ? skid_res_q : new_res;
      if (load_skid) skid_res_q <= new_res;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_imm     = out_res_q[XLEN-1:0];
  assign out_illegal = out_res_q[XLEN];

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
  import datatypes::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_ir;
  logic [2:0]  in_type;
  logic        in_rvc;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_ir(in_ir), .in_type(in_type), .in_rvc(in_rvc),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_illegal(out_illegal32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_ir(in_ir), .in_type(in_type), .in_rvc(in_rvc),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_illegal(out_illegal64)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint imm;
    bit     ill;
  } exp_t;

  function automatic longint sx(longint v, int bits);
    if (v[bits-1]) return v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic longint fld(logic [31:0] w, int hi, int lo, int dst);
    return ((longint'(w) >> lo) & ((longint'(1) << (hi - lo + 1)) - 1)) << dst;
  endfunction

  function automatic exp_t model(logic [2:0] ty, logic [31:0] ir, logic rvc);
    exp_t e;
    e.imm = 0;
    e.ill = 0;
    if (!rvc) begin
      case (ty)
        3'd0: e.imm = sx(fld(ir, 31, 20, 0), 12);
        3'd1: e.imm = sx(fld(ir, 31, 25, 5) + fld(ir, 11, 7, 0), 12);
        3'd2: e.imm = sx(fld(ir, 31, 31, 12) + fld(ir, 7, 7, 11)
                         + fld(ir, 30, 25, 5) + fld(ir, 11, 8, 1), 13);
        3'd3: e.imm = sx(fld(ir, 31, 12, 12), 32);
        3'd4: e.imm = sx(fld(ir, 31, 31, 20) + fld(ir, 19, 12, 12)
                         + fld(ir, 20, 20, 11) + fld(ir, 30, 21, 1), 21);
        default: e.ill = 1;
      endcase
    end else begin
`ifdef IMM_GEN_RVC_EN
      case (ty)
        3'd0: e.imm = sx(fld(ir, 12, 12, 5) + fld(ir, 6, 2, 0), 6);
        3'd2: e.imm = sx(fld(ir, 12, 12, 8) + fld(ir, 11, 10, 3) + fld(ir, 6, 5, 6)
                         + fld(ir, 4, 3, 1) + fld(ir, 2, 2, 5), 9);
        3'd4: e.imm = sx(fld(ir, 12, 12, 11) + fld(ir, 11, 11, 4) + fld(ir, 10, 9, 8)
                         + fld(ir, 8, 8, 10) + fld(ir, 7, 7, 6) + fld(ir, 6, 6, 7)
                         + fld(ir, 5, 3, 1) + fld(ir, 2, 2, 5), 12);
        default: e.ill = 1;
      endcase
`else
      e.ill = 1;
`endif
    end
    return e;
  endfunction

  // ---------------- compare process ----------------
  exp_t mq[$];

  initial begin
    @(posedge clk);
    forever begin
      int   sz;
      exp_t h;
      @(negedge clk);
      sz = mq.size();
      chk("out_valid32", 64'(out_valid32), 64'(sz != 0));
      chk("out_valid64", 64'(out_valid64), 64'(sz != 0));
      chk("in_ready32",  64'(in_ready32),  64'(sz != 2));
      chk("in_ready64",  64'(in_ready64),  64'(sz != 2));
      if (sz != 0) begin
        h = mq[0];
        chk("imm32", 64'(out_imm32), 64'(h.imm[31:0]));
        chk("imm64", out_imm64, h.imm);
        chk("ill32", 64'(out_illegal32), 64'(h.ill));
        chk("ill64", 64'(out_illegal64), 64'(h.ill));
      end
      if (rst) begin
        mq.delete();
      end else begin
        bit acc;
        acc = in_valid && (sz < 2);
        if (out_ready && sz != 0) void'(mq.pop_front());
        if (acc) mq.push_back(model(in_type, in_ir, in_rvc));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(logic [2:0] ty, logic [31:0] ir, logic rvc);
    in_valid = 1'b1;
    in_type  = ty;
    in_ir    = ir;
    in_rvc   = rvc;
  endtask

  task automatic lit(string nm, logic [63:0] e64, logic ill);
    @(negedge clk);
    chk({nm, "_v"},     64'(out_valid32 & out_valid64), 64'd1);
    chk({nm, "_imm32"}, 64'(out_imm32), 64'(e64[31:0]));
    chk({nm, "_imm64"}, out_imm64, e64);
    chk({nm, "_ill"},   64'(out_illegal32 | out_illegal64), 64'(ill));
    chk({nm, "_ill2"},  64'(out_illegal32 & out_illegal64), 64'(ill));
  endtask

  initial begin
    exp_t m;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_ir     = '0;
    in_type   = '0;
    in_rvc    = 1'b0;
    out_ready = 1'b1;

    // Pin the model with hand-computed values.
    m = model(3'd0, 32'hFFF00093, 1'b0); chk("model_addi", m.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    m = model(3'd4, 32'hFFDFF06F, 1'b0); chk("model_jal",  m.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    m = model(3'd3, 32'h80000037, 1'b0); chk("model_lui",  m.imm, 64'hFFFF_FFFF_8000_0000);
    m = model(3'd2, 32'hFE000EE3, 1'b0); chk("model_beq",  m.imm, 64'hFFFF_FFFF_FFFF_FFFC);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid32 | out_valid64), 64'd0);
    chk("rst_in_ready",  64'(in_ready32 & in_ready64),   64'd1);
    chk("rst_out_imm",   out_imm64 | 64'(out_imm32),     64'd0);
    chk("rst_out_ill",   64'(out_illegal32 | out_illegal64), 64'd0);

    // Streaming, one word per cycle.
    @(posedge clk); #1;
    rst = 1'b0;
    put(3'd0, 32'hFFF00093, 1'b0);                          // addi x1,x0,-1
    tick(); put(3'd4, 32'hFFDFF06F, 1'b0);                  // jal x0,-4
    lit("addi", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    tick(); put(3'd3, 32'h123450B7, 1'b0);                  // lui
    lit("jal", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    tick(); put(3'd3, 32'h80000037, 1'b0);
    lit("lui", 64'h0000_0000_1234_5000, 1'b0);
    tick(); put(3'd1, 32'hFE000C23, 1'b0);                  // sw offset -8
    lit("lui_neg", 64'hFFFF_FFFF_8000_0000, 1'b0);
    tick(); put(3'd2, 32'hFE000EE3, 1'b0);                  // beq offset -4
    lit("sw", 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    tick(); put(3'd7, 32'hFFFFFFFF, 1'b0);                  // unsupported type
    lit("beq", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    tick(); put(3'd0, 32'h000050FD, 1'b1);                  // c.li x1,-1
    lit("bad_type", 64'd0, 1'b1);
    tick(); put(3'd4, 32'h0000BFFD, 1'b1);                  // c.j -2
`ifdef IMM_GEN_RVC_EN
    lit("c_li", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
`else
    lit("c_li_off", 64'd0, 1'b1);
`endif
    tick(); put(3'd2, 32'h0000DC7D, 1'b1);                  // CB word
    tick(); put(3'd1, 32'h0000C004, 1'b1);                  // compressed S: illegal
    tick(); put(3'd2, 32'h00000040, 1'b1);                  // CB, positive
    tick(); in_valid = 1'b0;
    tick(); tick();

    // Backpressure: three back-to-back words with downstream stalled.
    out_ready = 1'b0;
    put(3'd0, 32'hFFF00093, 1'b0);
    tick(); put(3'd3, 32'h123450B7, 1'b0);
    tick(); put(3'd2, 32'hFE000EE3, 1'b0);
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready32 | in_ready64), 64'd0);
    repeat (2) begin
      tick();
      lit("bp_hold", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    end
    tick(); out_ready = 1'b1;
    lit("bp_first", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    tick();
    lit("bp_second", 64'h0000_0000_1234_5000, 1'b0);
    chk("bp_in_ready_back", 64'(in_ready32 & in_ready64), 64'd1);
    tick(); in_valid = 1'b0;
    lit("bp_third", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    tick();
    @(negedge clk);
    chk("bp_drained", 64'(out_valid32 | out_valid64), 64'd0);

    // Reset while full: both entries and the pending word must vanish.
    tick(); out_ready = 1'b0;
    put(3'd0, 32'hFFF00093, 1'b0);
    tick(); put(3'd4, 32'hFFDFF06F, 1'b0);
    tick(); put(3'd3, 32'h123450B7, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_full", 64'(in_ready32 | in_ready64), 64'd0);
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid32 | out_valid64), 64'd0);
    chk("mid_rst_ready", 64'(in_ready32 & in_ready64),   64'd1);
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("post_rst_quiet", 64'(out_valid32 | out_valid64), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
